// File: rtl/data_mem_pkg.sv
// Shared constants for the data memory load/store unit.
package data_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/data_mem_align.sv
// Lane steering for stores and sign/zero extension for loads.
module data_mem_align
  import data_mem_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdword,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] rdata,
  output logic        bad
);

  logic [31:0] sel;
  logic        mis;
  logic        ill;

  assign sel = rdword >> {off, 3'b000};

  always_comb begin
    be    = 4'b0000;
    wword = wdata;
    mis   = 1'b0;
    unique case (funct3[1:0])
      2'b00: begin
        be    = 4'b0001 << off;
        wword = {4{wdata[7:0]}};
      end
      2'b01: begin
        be    = off[1] ? 4'b1100 : 4'b0011;
        wword = {2{wdata[15:0]}};
        mis   = off[0];
      end
      2'b10: begin
        be    = 4'b1111;
        mis   = off != 2'b00;
      end
      2'b11: begin
        be    = 4'b0000;
      end
    endcase
  end

  // funct3[2] selects zero-extension on loads
  always_comb begin
    rdata = 32'h0;
    unique case (funct3)
      F3_B:    rdata = {{24{sel[7]}}, sel[7:0]};
      F3_BU:   rdata = {24'h0, sel[7:0]};
      F3_H:    rdata = {{16{sel[15]}}, sel[15:0]};
      F3_HU:   rdata = {16'h0, sel[15:0]};
      F3_W:    rdata = rdword;
      default: rdata = 32'h0;
    endcase
  end

  assign ill = we ? (funct3[2] || funct3[1:0] == 2'b11)
                  : (funct3 == 3'b011 || funct3[2:1] == 2'b11);
  assign bad = ill | mis;

endmodule

// File: rtl/data_mem_lsu.sv
// Byte-addressed data memory with sub-word access and post-reset clear.
module data_mem_lsu
  import data_mem_pkg::*;
#(
  parameter int DEPTH          = 1024,
  parameter int ADDR_W         = 32,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              init_done
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0] mem [DEPTH];

  state_e      state;
  logic [AW-1:0] cnt;
  logic [AW-1:0] widx;
  logic        oor;
  logic        acc;
  logic        err;
  logic [3:0]  be;
  logic [31:0] wword;
  logic [31:0] rdata;
  logic [31:0] rdword;
  logic        bad;

  assign widx   = req_addr[AW+1:2];
  assign rdword = mem[widx];

  generate
    if (ADDR_W - 2 > AW) begin : g_oor
      assign oor = |req_addr[ADDR_W-1:AW+2];
    end else begin : g_no_oor
      assign oor = 1'b0;
    end
  endgenerate

  data_mem_align u_align (
    .we     (req_we),
    .funct3 (req_funct3),
    .off    (req_addr[1:0]),
    .wdata  (req_wdata),
    .rdword (rdword),
    .be     (be),
    .wword  (wword),
    .rdata  (rdata),
    .bad    (bad)
  );

  assign req_ready = state == RUN;
  assign init_done = state == RUN;
  assign acc       = req_valid && req_ready;
  assign err       = bad | oor;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= INIT;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 32'h0;
    end else begin
      if (state == INIT) begin
        cnt <= cnt + 1'b1;
        if (CLEAR_ON_RESET == 0 || cnt == AW'(DEPTH - 1))
          state <= RUN;
      end
      rsp_valid <= acc;
      rsp_err   <= acc && err;
      rsp_rdata <= (acc && !req_we && !err) ? rdata : 32'h0;
    end
  end

  // Memory is never written on a reset edge
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == INIT) begin
        if (CLEAR_ON_RESET != 0)
          mem[cnt] <= 32'h0;
      end else if (acc && req_we && !err) begin
        for (int i = 0; i < 4; i++)
          if (be[i])
            mem[widx][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed checks for data_mem_lsu with a 16-word memory.
module tb_data_mem_lsu;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        init_done;

  int errors = 0;
  int checks = 0;

  data_mem_lsu #(
    .DEPTH          (DEPTH),
    .ADDR_W         (32),
    .CLEAR_ON_RESET (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .init_done  (init_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic req(input logic we, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input string tag, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] exp,
                      input logic eerr);
    req(1'b0, f3, a, 32'h0);
    chk({tag, "_vld"}, 32'(rsp_valid), 32'h1);
    chk({tag, "_err"}, 32'(rsp_err), 32'(eerr));
    chk(tag, rsp_rdata, exp);
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!req_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(tag, n, DEPTH);
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_done", 32'(init_done), 32'h0);
    chk("rst_rvld", 32'(rsp_valid), 32'h0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_err", 32'(rsp_err), 32'h0);

    @(negedge clk);
    rst = 1'b0;
    wait_ready("clear_edges");
    chk("init_done", 32'(init_done), 32'h1);

    for (int i = 0; i < DEPTH; i++)
      load($sformatf("zero%0d", i), 3'b010, 32'(i * 4), 32'h0, 1'b0);
    idle();
    chk("idle_vld", 32'(rsp_valid), 32'h0);

    req(1'b1, 3'b010, 32'h8, 32'h11223344);
    chk("sw_ack", 32'(rsp_valid), 32'h1);
    chk("sw_rdata", rsp_rdata, 32'h0);
    req(1'b1, 3'b000, 32'h9, 32'h000000AA);
    req(1'b1, 3'b001, 32'hA, 32'h0000BEEF);
    load("lanes", 3'b010, 32'h8, 32'hBEEFAA44, 1'b0);

    req(1'b1, 3'b010, 32'h0, 32'h80FF7F01);
    load("lb", 3'b000, 32'h2, 32'hFFFFFFFF, 1'b0);
    load("lbu", 3'b100, 32'h2, 32'h000000FF, 1'b0);
    load("lh", 3'b001, 32'h2, 32'hFFFF80FF, 1'b0);
    load("lhu", 3'b101, 32'h0, 32'h00007F01, 1'b0);
    load("lb1", 3'b000, 32'h0, 32'h00000001, 1'b0);

    req(1'b1, 3'b010, 32'h6, 32'hDEADBEEF);
    chk("sw_mis_err", 32'(rsp_err), 32'h1);
    chk("sw_mis_rd", rsp_rdata, 32'h0);
    load("sw_mis_mem", 3'b010, 32'h4, 32'h0, 1'b0);
    load("lh_mis", 3'b001, 32'h3, 32'h0, 1'b1);
    load("ld_f3_011", 3'b011, 32'h0, 32'h0, 1'b1);
    load("lw_oor", 3'b010, 32'(DEPTH * 4), 32'h0, 1'b1);
    req(1'b1, 3'b010, 32'(DEPTH * 4), 32'h12345678);
    chk("sw_oor_err", 32'(rsp_err), 32'h1);
    req(1'b1, 3'b100, 32'h0, 32'h12345678);
    chk("st_f3_100", 32'(rsp_err), 32'h1);
    load("oor_mem", 3'b010, 32'h0, 32'h80FF7F01, 1'b0);

    idle();
    req(1'b1, 3'b010, 32'h10, 32'hCAFEF00D);
    chk("b2b_vld0", 32'(rsp_valid), 32'h1);
    load("b2b", 3'b010, 32'h10, 32'hCAFEF00D, 1'b0);
    idle();
    chk("b2b_end", 32'(rsp_valid), 32'h0);

    @(negedge clk);
    rst        = 1'b1;
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h14;
    req_wdata  = 32'h55555555;
    @(posedge clk);
    #1;
    chk("rst_drop_vld", 32'(rsp_valid), 32'h0);
    chk("rst_drop_rdy", 32'(req_ready), 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    rst       = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("mid_init_rdy", 32'(req_ready), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_ready("restart_edges");
    load("reclear", 3'b010, 32'h8, 32'h0, 1'b0);
    load("rst_store", 3'b010, 32'h14, 32'h0, 1'b0);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
